game_event_controller: RTL and testbench
========================================

Name: game_event_controller

Overview:
- Parametrised successor to the single-frame collision check in the game top level.
- Once per video frame, compares the player, sword and sheep tiles against N dragon segments, scanning one segment per clock.
- Owns the game rule state: lives, invulnerability frames, score and the IDLE/PLAY/GAME_OVER sequencing.
- Drives the PPU heart entity, the APU trigger pulses and the background colour select.

Parameters:
SEGMENTS, 7, number of dragon segments scanned (>=1)
POS_W, 8, tile position width (xxxx_yyyy)
LIVES_W, 2, lives counter width
START_LIVES, 3, lives loaded at game start (1..2^LIVES_W-1)
IFRAMES, 60, invulnerability frames after a player hit (>=1)
SCORE_W, 8, score counter width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
frame_end  in  1  one-cycle pulse per frame from sync_generator
start  in  1  start/restart request (level), sampled on frame_end
player_pos  in  POS_W  player tile
sword_pos  in  POS_W  sword tile
sword_active  in  1  sword visible this frame
sheep_pos  in  POS_W  sheep tile
seg_pos  in  SEGMENTS*POS_W  segment i at bits [i*POS_W +: POS_W]; segment 0 is the head
seg_active  in  SEGMENTS  per-segment visible flag
state  out  2  00 IDLE, 01 PLAY, 10 SCAN (scan/resolve in progress), 11 GAME_OVER
lives  out  LIVES_W  remaining lives
score  out  SCORE_W  dragon segments struck, saturating
invulnerable  out  1  high while the invulnerability counter is non-zero
player_hit  out  1  one-cycle pulse, a life was lost
sword_hit  out  1  one-cycle pulse, the sword struck a segment
sheep_eaten  out  1  one-cycle pulse, a segment overlapped the sheep
hit_seg_idx  out  max(1,$clog2(SEGMENTS))  lowest segment index struck by the sword, held until the next sword hit
game_over  out  1  equals (state==GAME_OVER)

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, lives=START_LIVES, score=0, invulnerability counter=0, all pulses=0, hit_seg_idx=0, scan flags cleared. Reset mid-scan aborts the scan with no pulses.
- IDLE: on a frame_end cycle with start=1 -> PLAY; lives reload to START_LIVES; score clears to 0.
- PLAY, on frame_end:
  - Register snapshots of player_pos, sword_pos, sword_active, sheep_pos, seg_pos and seg_active.
  - Clear the flags, set idx=0 and go to SCAN.
  - Decrement the invulnerability counter, saturating at 0.
- SCAN, one segment per cycle at index idx. Only segments with seg_active[idx]=1 participate.
  - Player flag: segment tile equals player tile.
  - Sword flag: sword_active and segment tile equals sword tile. Record idx only on the first sword match in the scan.
  - Sheep flag: segment tile equals sheep tile.
  - After idx=SEGMENTS-1, go to RESOLVE (encoded as state 10).
- RESOLVE (one cycle), outputs registered:
  - Player flag with counter=0: lives -= 1, counter loads IFRAMES, player_hit pulses. If lives becomes 0, go to GAME_OVER; otherwise go to PLAY.
  - Player flag with counter!=0: ignored, no pulse.
  - Sword flag: score += 1, saturating at 2^SCORE_W-1. sword_hit pulses and hit_seg_idx updates.
  - Sheep flag: sheep_eaten pulses.
  - All applicable events fire in the same cycle. A sword hit still scores on the frame that ends the game.
- Latency: pulses are high exactly one cycle, SEGMENTS+2 cycles after the frame_end cycle.
- frame_end arriving during SCAN/RESOLVE is ignored. The frame period must exceed SEGMENTS+2 cycles.
- GAME_OVER: holds lives=0 and score. On a frame_end with start=1 -> PLAY with reload, counter=0.
- Snapshotted inputs make scan results immune to input changes mid-scan.

Test Plan:
- Reset then start=1 on frame_end -> state=01, lives=3, score=0; no pulses over 10 frames with all segments away from every entity.
- Segment 4 active at player tile 0x35, counter=0 -> player_hit exactly 9 cycles after frame_end (SEGMENTS=7), lives=2, invulnerable=1. The same overlap for the next 59 frames -> no further hits. Hit again on frame 61 -> lives=1.
- Sword at 0x22 active, segments 2 and 5 both at 0x22 -> one sword_hit pulse, score +1, hit_seg_idx=2. Same overlap with seg_active[2]=0 -> hit_seg_idx=5.
- lives=1, player and sword hit in the same frame -> player_hit and sword_hit in the same cycle, lives=0, score incremented, state=11, game_over=1. start on the next frame_end -> lives=3, score=0.
- score=255 plus a sword hit -> score stays 255 and sword_hit still pulses. Sheep overlapping segment 0 -> sheep_eaten pulse, score unchanged.
- rst_n low during SCAN cycle 3 -> no pulses; state=IDLE, lives=3 on the next cycle. frame_end pulsed during SCAN -> ignored, exactly one resolve per scan.

Source files
------------

// File: rtl/game_event_controller.sv
// game_event_controller: per-frame dragon segment collision scan and game rule state
//   clk, rst_n                    clock, synchronous active-low reset
//   frame_end, start              frame pulse, start/restart level
//   player_pos, sword_pos,
//   sword_active, sheep_pos       entity tiles (xxxx_yyyy)
//   seg_pos, seg_active           packed dragon segment tiles and visible flags
//   state, game_over              00 IDLE, 01 PLAY, 10 SCAN/RESOLVE, 11 GAME_OVER
//   lives, score, invulnerable    game rule state
//   player_hit, sword_hit,
//   sheep_eaten, hit_seg_idx      event pulses and last struck segment
module game_event_controller #(
  parameter int SEGMENTS    = 7,
  parameter int POS_W       = 8,
  parameter int LIVES_W     = 2,
  parameter int START_LIVES = 3,
  parameter int IFRAMES     = 60,
  parameter int SCORE_W     = 8,
  localparam int IDX_W      = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1,
  localparam int CNT_W      = $clog2(IFRAMES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_end,
  input  logic                      start,
  input  logic [POS_W-1:0]          player_pos,
  input  logic [POS_W-1:0]          sword_pos,
  input  logic                      sword_active,
  input  logic [POS_W-1:0]          sheep_pos,
  input  logic [SEGMENTS*POS_W-1:0] seg_pos,
  input  logic [SEGMENTS-1:0]       seg_active,
  output logic [1:0]                state,
  output logic [LIVES_W-1:0]        lives,
  output logic [SCORE_W-1:0]        score,
  output logic                      invulnerable,
  output logic                      player_hit,
  output logic                      sword_hit,
  output logic                      sheep_eaten,
  output logic [IDX_W-1:0]          hit_seg_idx,
  output logic                      game_over
);
  // RESOLVE shares the externally visible code 10 with SCAN; bit 2 tells them apart
  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_PLAY = 3'b001,
    S_SCAN = 3'b010,
    S_OVER = 3'b011,
    S_RES  = 3'b110
  } st_t;
  st_t st;
  logic [POS_W-1:0] player_q, sword_q, sheep_q, cur;
  logic sword_act_q, cur_act, pf, sf, hf;
  logic [SEGMENTS*POS_W-1:0] seg_q;
  logic [SEGMENTS-1:0] seg_act_q;
  logic [IDX_W-1:0] idx, sidx;
  logic [CNT_W-1:0] cnt;
  assign cur          = seg_q[idx*POS_W +: POS_W];
  assign cur_act      = seg_act_q[idx];
  assign state        = st[1:0];
  assign game_over    = st == S_OVER;
  assign invulnerable = cnt != '0;
  always_ff @(posedge clk) begin
    player_hit  <= 1'b0;
    sword_hit   <= 1'b0;
    sheep_eaten <= 1'b0;
    if (!rst_n) begin
      st          <= S_IDLE;
      lives       <= LIVES_W'(START_LIVES);
      score       <= '0;
      cnt         <= '0;
      hit_seg_idx <= '0;
      idx         <= '0;
      sidx        <= '0;
      pf          <= 1'b0;
      sf          <= 1'b0;
      hf          <= 1'b0;
    end else begin
      case (st)
        S_IDLE, S_OVER: if (frame_end && start) begin
          st    <= S_PLAY;
          lives <= LIVES_W'(START_LIVES);
          score <= '0;
          cnt   <= '0;
        end
        S_PLAY: if (frame_end) begin
          player_q    <= player_pos;
          sword_q     <= sword_pos;
          sword_act_q <= sword_active;
          sheep_q     <= sheep_pos;
          seg_q       <= seg_pos;
          seg_act_q   <= seg_active;
          pf          <= 1'b0;
          sf          <= 1'b0;
          hf          <= 1'b0;
          idx         <= '0;
          cnt         <= (cnt == '0) ? '0 : cnt - 1'b1;
          st          <= S_SCAN;
        end
        S_SCAN: begin
          if (cur_act) begin
            if (cur == player_q) pf <= 1'b1;
            if (cur == sheep_q) hf <= 1'b1;
            // only the lowest struck index is kept
            if (sword_act_q && cur == sword_q && !sf) begin
              sf   <= 1'b1;
              sidx <= idx;
            end
          end
          if (idx == IDX_W'(SEGMENTS - 1)) st <= S_RES;
          else idx <= idx + 1'b1;
        end
        S_RES: begin
          st          <= S_PLAY;
          sheep_eaten <= hf;
          if (pf && cnt == '0) begin
            lives      <= lives - 1'b1;
            cnt        <= CNT_W'(IFRAMES);
            player_hit <= 1'b1;
            if (lives == LIVES_W'(1)) st <= S_OVER;
          end
          if (sf) begin
            score       <= (&score) ? score : score + 1'b1;
            sword_hit   <= 1'b1;
            hit_seg_idx <= sidx;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_game_event_controller.sv
// tb_game_event_controller: randomized and directed checks against a frame-level game model
module tb_game_event_controller;
  localparam int N = 7, PW = 8, LW = 2, SL = 3, IFR = 60, SW = 8, IW = 3;
  logic clk = 1'b0, rst_n = 1'b0, frame_end = 1'b0, start = 1'b0, sword_active = 1'b0;
  logic [PW-1:0] player_pos = '0, sword_pos = '0, sheep_pos = '0;
  logic [PW-1:0] segs [N];
  logic [N*PW-1:0] seg_pos;
  logic [N-1:0] seg_active = '0;
  logic [1:0] state;
  logic [LW-1:0] lives;
  logic [SW-1:0] score;
  logic [IW-1:0] hit_seg_idx;
  logic invulnerable, player_hit, sword_hit, sheep_eaten, game_over;
  logic [2:0] pulses;
  int n_cmp = 0, n_bad = 0;
  int m_st = 0, m_lives = SL, m_score = 0, m_cnt = 0, m_idx = 0;
  game_event_controller dut (
    .clk(clk), .rst_n(rst_n), .frame_end(frame_end), .start(start),
    .player_pos(player_pos), .sword_pos(sword_pos), .sword_active(sword_active),
    .sheep_pos(sheep_pos), .seg_pos(seg_pos), .seg_active(seg_active),
    .state(state), .lives(lives), .score(score), .invulnerable(invulnerable),
    .player_hit(player_hit), .sword_hit(sword_hit), .sheep_eaten(sheep_eaten),
    .hit_seg_idx(hit_seg_idx), .game_over(game_over)
  );
  always #5 clk = ~clk;
  always_comb for (int i = 0; i < N; i++) seg_pos[i*PW +: PW] = segs[i];
  assign pulses = {player_hit, sword_hit, sheep_eaten};
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_status(input string tag);
    check({tag, "_state"}, int'(state), m_st == 4 ? 2 : m_st);
    check({tag, "_lives"}, int'(lives), m_lives);
    check({tag, "_score"}, int'(score), m_score);
    check({tag, "_inv"}, int'(invulnerable), int'(m_cnt != 0));
    check({tag, "_idx"}, int'(hit_seg_idx), m_idx);
    check({tag, "_go"}, int'(game_over), int'(m_st == 3));
  endtask
  task automatic clear_scene();
    player_pos = 8'h00;
    sword_pos = 8'h01;
    sword_active = 1'b1;
    sheep_pos = 8'h02;
    for (int i = 0; i < N; i++) segs[i] = 8'h80 + PW'(i);
    seg_active = '1;
  endtask
  task automatic frame(input bit st_req, input bit inj, input int rst_at);
    logic [PW-1:0] sv_segs [N];
    logic [PW-1:0] sp, ss, sh;
    logic sa;
    logic [N-1:0] sact;
    bit pf, sf, hf;
    int si, e, nl, ns, nc, ni, nst;
    @(negedge clk);
    start = st_req;
    frame_end = 1'b1;
    if (m_st != 1) begin
      if (st_req) begin
        m_st = 1; m_lives = SL; m_score = 0; m_cnt = 0;
      end
      @(negedge clk);
      frame_end = 1'b0;
      start = 1'b0;
      check("idle_pulse", int'(pulses), 0);
      check_status("idle");
      return;
    end
    pf = 0; sf = 0; hf = 0; si = 0;
    for (int i = 0; i < N; i++) if (seg_active[i]) begin
      if (segs[i] == player_pos) pf = 1;
      if (segs[i] == sheep_pos) hf = 1;
      if (sword_active && segs[i] == sword_pos && !sf) begin sf = 1; si = i; end
    end
    nc = m_cnt > 0 ? m_cnt - 1 : 0;
    nl = m_lives; ns = m_score; ni = m_idx; e = 0;
    if (pf && nc == 0) begin nl = nl - 1; nc = IFR; e += 4; end
    if (sf) begin ns = ns < 255 ? ns + 1 : 255; ni = si; e += 2; end
    if (hf) e += 1;
    nst = (pf && e >= 4 && nl == 0) ? 3 : 1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        frame_end = 1'b0;
        start = 1'b0;
        sv_segs = segs; sp = player_pos; ss = sword_pos; sh = sheep_pos; sa = sword_active; sact = seg_active;
        for (int i = 0; i < N; i++) segs[i] = PW'($urandom);
        player_pos = PW'($urandom); sword_pos = PW'($urandom); sheep_pos = PW'($urandom);
        sword_active = 1'($urandom); seg_active = N'($urandom);
      end
      if (k == 3) frame_end = inj;
      if (k == 4) frame_end = 1'b0;
      if (rst_at != 0 && k == rst_at) begin
        check("pre_rst_pulse", int'(pulses), 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        frame_end = 1'b0;
        m_st = 0; m_lives = SL; m_score = 0; m_cnt = 0; m_idx = 0;
        check("rst_pulse", int'(pulses), 0);
        check_status("rst");
        segs = sv_segs; player_pos = sp; sword_pos = ss; sheep_pos = sh; sword_active = sa; seg_active = sact;
        return;
      end
      if (k < 9) begin
        check("scan_pulse", int'(pulses), 0);
        check("scan_state", int'(state), 2);
      end
    end
    m_st = nst; m_lives = nl; m_score = ns; m_cnt = nc; m_idx = ni;
    check("res_pulse", int'(pulses), e);
    check_status("res");
    @(negedge clk);
    check("after_pulse", int'(pulses), 0);
    segs = sv_segs; player_pos = sp; sword_pos = ss; sheep_pos = sh; sword_active = sa; seg_active = sact;
  endtask
  initial begin
    clear_scene();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset_pulse", int'(pulses), 0);
    check_status("reset");
    frame(1, 0, 0);
    check("start_state", int'(state), 1);
    check("start_lives", int'(lives), 3);
    repeat (10) frame(0, 0, 0);
    segs[4] = 8'h35;
    player_pos = 8'h35;
    frame(0, 0, 0);
    check("first_hit_lives", int'(lives), 2);
    check("first_hit_inv", int'(invulnerable), 1);
    repeat (59) frame(0, 0, 0);
    check("invuln_lives", int'(lives), 2);
    frame(0, 0, 0);
    check("second_hit_lives", int'(lives), 1);
    clear_scene();
    sword_pos = 8'h22; segs[2] = 8'h22; segs[5] = 8'h22;
    frame(0, 0, 0);
    check("sword_idx_lowest", int'(hit_seg_idx), 2);
    seg_active[2] = 1'b0;
    frame(0, 0, 0);
    check("sword_idx_masked", int'(hit_seg_idx), 5);
    clear_scene();
    while (m_cnt > 1) frame(0, 0, 0);
    segs[3] = player_pos; sword_pos = 8'h22; segs[6] = 8'h22;
    frame(0, 0, 0);
    check("end_state", int'(state), 3);
    check("end_lives", int'(lives), 0);
    check("end_go", int'(game_over), 1);
    clear_scene();
    frame(0, 0, 0);
    check("over_hold", int'(state), 3);
    frame(1, 0, 0);
    check("restart_lives", int'(lives), 3);
    check("restart_score", int'(score), 0);
    segs[1] = sword_pos;
    repeat (256) frame(0, 0, 0);
    check("score_sat", int'(score), 255);
    clear_scene();
    sheep_pos = segs[0];
    frame(0, 0, 0);
    check("sheep_score", int'(score), 255);
    segs[2] = player_pos; segs[5] = sword_pos;
    frame(0, 0, 3);
    frame(1, 0, 0);
    clear_scene();
    segs[4] = sword_pos;
    frame(0, 1, 0);
    check("inject_state", int'(state), 1);
    repeat (250) begin
      for (int i = 0; i < N; i++) segs[i] = PW'($urandom_range(0, 15));
      player_pos = PW'($urandom_range(0, 15));
      sword_pos = PW'($urandom_range(0, 15));
      sheep_pos = PW'($urandom_range(0, 15));
      sword_active = 1'($urandom);
      seg_active = N'($urandom);
      frame(1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0 ? int'($urandom_range(1, 8)) : 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
